// File: rtl/wb_latch_md.sv
// wb_latch_md -- writeback-stage latch between the memory stage and the
// register file write port.
//
// Captures the instruction/result leaving memory and drives the register
// write one cycle later. A mult/div parks the latch in WAIT_MD with the
// upstream pipeline stalled until the multdiv unit answers. A watchdog
// turns a unit that never answers into a timeout exception. All exceptions
// are written to STATUS_REG as a per-cause code.
//
// Ports:
//   clock        rising-edge clock
//   clear        asynchronous active-high reset
//   ir_in        instruction leaving the memory stage
//   data_in      ALU/memory result for ir_in
//   exc_in       single-cycle exception flag for ir_in
//   md_result    multdiv result
//   md_ready     multdiv result valid (one-cycle pulse)
//   md_exception multdiv exception, qualified by md_ready
//   data_out     register file write data
//   rd           register file write index
//   we           register file write enable
//   stall        freeze upstream stages
//   timeout      sticky watchdog flag
module wb_latch_md #(
  parameter int WIDTH       = 32,
  parameter int STATUS_REG  = 30,
  parameter int ALU_EXC     = 1,
  parameter int MULT_EXC    = 4,
  parameter int DIV_EXC     = 5,
  parameter int TIMEOUT     = 64,
  parameter int TIMEOUT_EXC = 6
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [31:0]      ir_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic             exc_in,
  input  logic [WIDTH-1:0] md_result,
  input  logic             md_ready,
  input  logic             md_exception,
  output logic [WIDTH-1:0] data_out,
  output logic [4:0]       rd,
  output logic             we,
  output logic             stall,
  output logic             timeout
);

  typedef enum logic [1:0] {IDLE, WAIT_MD, WRITE_MD} state_t;

  localparam logic [4:0]  STATUS_IDX = 5'(STATUS_REG);
  localparam logic [15:0] CNT_LAST   = 16'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [31:0]      ir;
  logic [WIDTH-1:0] data;
  logic             exc;
  logic [WIDTH-1:0] md_res;
  logic             md_exc;
  logic             forced_exc;
  logic             timeout_flag;
  logic [15:0]      cnt;
  logic             cnt_last;
  logic             we_raw;
  logic             unused_ir_bits;

  function automatic logic is_md(input logic [31:0] i);
    return (i[31:27] == 5'b00000) && ((i[6:2] == 5'b00110) || (i[6:2] == 5'b00111));
  endfunction

  assign cnt_last       = (cnt == CNT_LAST);
  assign timeout        = timeout_flag;
  assign unused_ir_bits = ^{ir[21:7], ir[1:0]};

  // State register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_next;
  end

  // Next state. IDLE and WRITE_MD both accept a new instruction and branch
  // on the incoming one, so a back-to-back multdiv skips IDLE entirely.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, WRITE_MD: state_next = is_md(ir_in) ? WAIT_MD : IDLE;
      WAIT_MD:        if (md_ready || cnt_last) state_next = WRITE_MD;
      default:        state_next = IDLE;
    endcase
  end

  // Datapath registers. The counter is held at zero outside WAIT_MD so it
  // starts from zero on every entry. md_ready wins over the watchdog when
  // both land in the final wait cycle.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      ir           <= '0;
      data         <= '0;
      exc          <= 1'b0;
      md_res       <= '0;
      md_exc       <= 1'b0;
      forced_exc   <= 1'b0;
      timeout_flag <= 1'b0;
      cnt          <= '0;
    end else if (state != WAIT_MD) begin
      ir   <= ir_in;
      data <= data_in;
      exc  <= exc_in;
      cnt  <= '0;
    end else begin
      cnt <= cnt + 16'd1;
      if (md_ready) begin
        md_res     <= md_result;
        md_exc     <= md_exception;
        forced_exc <= 1'b0;
      end else if (cnt_last) begin
        forced_exc   <= 1'b1;
        timeout_flag <= 1'b1;
      end
    end
  end

  // Output decode from registered state only; register 0 is never written.
  always_comb begin
    data_out = data;
    rd       = 5'd0;
    we_raw   = 1'b0;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        if (exc) begin
          rd       = STATUS_IDX;
          data_out = WIDTH'(ALU_EXC);
          we_raw   = 1'b1;
        end else if (!is_md(ir)) begin
          case (ir[31:27])
            5'b00000, 5'b00101, 5'b01000: begin rd = ir[26:22]; we_raw = 1'b1; end
            5'b00011:                     begin rd = 5'd31;     we_raw = 1'b1; end
            5'b10101:                     begin rd = STATUS_IDX; we_raw = 1'b1; end
            default:                      we_raw = 1'b0;
          endcase
        end
      end
      WAIT_MD: stall = 1'b1;
      WRITE_MD: begin
        we_raw = 1'b1;
        if (forced_exc) begin
          rd       = STATUS_IDX;
          data_out = WIDTH'(TIMEOUT_EXC);
        end else if (md_exc) begin
          rd       = STATUS_IDX;
          data_out = ir[2] ? WIDTH'(DIV_EXC) : WIDTH'(MULT_EXC);
        end else begin
          rd       = ir[26:22];
          data_out = md_res;
        end
      end
      default: stall = 1'b0;
    endcase
    we = we_raw && (rd != 5'd0);
  end

endmodule

// File: tb/tb_wb_latch_md.sv
// tb_wb_latch_md -- self-checking bench for wb_latch_md.
// Two instances share all inputs: dut (default TIMEOUT=64) and dut_to
// (TIMEOUT=8) for the watchdog scenarios.
module tb_wb_latch_md;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] ir_in, data_in, md_result;
  logic        exc_in, md_ready, md_exception;
  logic [31:0] data_out, t_data_out;
  logic [4:0]  rd, t_rd;
  logic        we, stall, timeout, t_we, t_stall, t_timeout;
  int          total = 0;
  int          bad = 0;

  always #5 clock = ~clock;

  wb_latch_md dut (
    .clock(clock), .clear(clear), .ir_in(ir_in), .data_in(data_in), .exc_in(exc_in),
    .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
    .data_out(data_out), .rd(rd), .we(we), .stall(stall), .timeout(timeout)
  );

  wb_latch_md #(.TIMEOUT(8)) dut_to (
    .clock(clock), .clear(clear), .ir_in(ir_in), .data_in(data_in), .exc_in(exc_in),
    .md_result(md_result), .md_ready(md_ready), .md_exception(md_exception),
    .data_out(t_data_out), .rd(t_rd), .we(t_we), .stall(t_stall), .timeout(t_timeout)
  );

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] dst, input logic [4:0] aluop);
    return {op, dst, 15'h0, aluop, 2'b00};
  endfunction

  // Reference: what a single-cycle instruction writes, straight from the class table.
  function automatic void ref_single(input logic [31:0] i, input logic [31:0] d, input logic e,
                                     output logic ewe, output logic [4:0] erd, output logic [31:0] edata);
    int op;
    op = int'(i[31:27]);
    edata = d;
    erd = 5'd0;
    if (e) begin
      erd = 5'd30; edata = 32'd1;
    end else if (op == 0 || op == 5 || op == 8) erd = i[26:22];
    else if (op == 3) erd = 5'd31;
    else if (op == 21) erd = 5'd30;
    ewe = (erd != 5'd0);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ir_in = 32'h0; data_in = 32'h0; exc_in = 1'b0;
    md_ready = 1'b0; md_exception = 1'b0; md_result = 32'h0;
  endtask

  // Present a multdiv, clock it in, then park ir_in on a non-writing nop.
  task automatic load_md(input logic [31:0] i);
    ir_in = i; exc_in = 1'b0; data_in = $urandom;
    step();
    ir_in = 32'h0; data_in = 32'h0;
  endtask

  // From the first wait cycle, wait n cycles then pulse md_ready.
  task automatic drive_wait(input int n);
    for (int i = 0; i <= n; i++) begin
      md_ready = (i == n);
      step();
    end
    md_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    idle_inputs();
    ir_in = mk(5'd5, 5'd3, 5'd0); data_in = 32'hFFFF;
    step(); step();
    total++; if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data: got %h want 0", data_out); end
    total++; if (rd !== 5'd0)        begin bad++; $display("FAIL reset_rd: got %0d want 0", rd); end
    total++; if (we !== 1'b0)        begin bad++; $display("FAIL reset_we: got %b want 0", we); end
    total++; if (stall !== 1'b0)     begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
    total++; if (timeout !== 1'b0)   begin bad++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    clear = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_addi();
    ir_in = 32'h28C0_0000; data_in = 32'd7;
    step();
    total++; if (rd !== 5'd3)        begin bad++; $display("FAIL addi_rd: got %0d want 3", rd); end
    total++; if (data_out !== 32'd7) begin bad++; $display("FAIL addi_data: got %h want 7", data_out); end
    total++; if (we !== 1'b1)        begin bad++; $display("FAIL addi_we: got %b want 1", we); end
    total++; if (stall !== 1'b0)     begin bad++; $display("FAIL addi_stall: got %b want 0", stall); end
    clear = 1'b1;
    #1;
    total++; if ({data_out, rd, we} !== 38'h0) begin bad++; $display("FAIL async_clear_outputs: got %h/%0d/%b want 0", data_out, rd, we); end
    clear = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_exc();
    ir_in = mk(5'd0, 5'd5, 5'd0); exc_in = 1'b1; data_in = 32'hCAFE;
    step();
    total++; if (rd !== 5'd30)       begin bad++; $display("FAIL exc_rd: got %0d want 30", rd); end
    total++; if (data_out !== 32'd1) begin bad++; $display("FAIL exc_data: got %h want 1", data_out); end
    total++; if (we !== 1'b1)        begin bad++; $display("FAIL exc_we: got %b want 1", we); end
    ir_in = mk(5'd0, 5'd0, 5'd0); exc_in = 1'b0; data_in = 32'h1234;
    step();
    total++; if (we !== 1'b0)        begin bad++; $display("FAIL rd0_we: got %b want 0", we); end
    idle_inputs();
  endtask

  task automatic test_mult_wait();
    int n;
    ir_in = mk(5'd0, 5'd4, 5'd6); data_in = 32'h0;
    step();
    ir_in = 32'h29C0_0000; data_in = 32'hABC;
    md_result = 32'h1234; md_exception = 1'b0;
    n = 0;
    while (stall && n < 40) begin
      n++;
      md_ready = (n == 11);
      step();
    end
    md_ready = 1'b0;
    total++; if (n !== 11)               begin bad++; $display("FAIL mult_stall_len: got %0d want 11", n); end
    total++; if (rd !== 5'd4)            begin bad++; $display("FAIL mult_rd: got %0d want 4", rd); end
    total++; if (data_out !== 32'h1234)  begin bad++; $display("FAIL mult_data: got %h want 1234", data_out); end
    total++; if (we !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL mult_we_stall: got %b/%b want 1/0", we, stall); end
    step();
    total++; if (rd !== 5'd7 || data_out !== 32'hABC || we !== 1'b1) begin bad++; $display("FAIL held_addi: got %0d/%h/%b want 7/abc/1", rd, data_out, we); end
    idle_inputs();
    step();
  endtask

  task automatic test_md_exception();
    load_md(mk(5'd0, 5'd9, 5'd7));
    md_exception = 1'b1; md_result = 32'hBEEF;
    drive_wait(3);
    total++; if (rd !== 5'd30 || data_out !== 32'd5 || we !== 1'b1) begin bad++; $display("FAIL div_exc: got %0d/%h/%b want 30/5/1", rd, data_out, we); end
    load_md(mk(5'd0, 5'd9, 5'd6));
    drive_wait(2);
    total++; if (rd !== 5'd30 || data_out !== 32'd4 || we !== 1'b1) begin bad++; $display("FAIL mult_exc: got %0d/%h/%b want 30/4/1", rd, data_out, we); end
    idle_inputs();
    step();
  endtask

  task automatic test_timeout();
    int n;
    pulse_clear();
    load_md(mk(5'd0, 5'd12, 5'd7));
    n = 0;
    while (t_stall && n < 20) begin
      n++;
      step();
    end
    total++; if (n !== 8) begin bad++; $display("FAIL to_stall_len: got %0d want 8", n); end
    total++; if (t_rd !== 5'd30 || t_data_out !== 32'd6 || t_we !== 1'b1) begin bad++; $display("FAIL to_write: got %0d/%h/%b want 30/6/1", t_rd, t_data_out, t_we); end
    total++; if (t_timeout !== 1'b1) begin bad++; $display("FAIL to_flag: got %b want 1", t_timeout); end
    step(); step();
    total++; if (t_timeout !== 1'b1 || t_stall !== 1'b0) begin bad++; $display("FAIL to_sticky: got %b/%b want 1/0", t_timeout, t_stall); end
    pulse_clear();
    total++; if (t_timeout !== 1'b0) begin bad++; $display("FAIL to_cleared: got %b want 0", t_timeout); end
    load_md(mk(5'd0, 5'd12, 5'd7));
    md_result = 32'h55AA; md_exception = 1'b0;
    drive_wait(7);
    total++; if (t_rd !== 5'd12 || t_data_out !== 32'h55AA || t_we !== 1'b1) begin bad++; $display("FAIL to_last_ready: got %0d/%h/%b want 12/55aa/1", t_rd, t_data_out, t_we); end
    total++; if (t_timeout !== 1'b0) begin bad++; $display("FAIL to_last_flag: got %b want 0", t_timeout); end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    load_md(mk(5'd0, 5'd6, 5'd6));
    md_result = 32'h11;
    drive_wait(2);
    total++; if (rd !== 5'd6 || data_out !== 32'h11 || we !== 1'b1) begin bad++; $display("FAIL b2b_first: got %0d/%h/%b want 6/11/1", rd, data_out, we); end
    load_md(mk(5'd0, 5'd8, 5'd6));
    total++; if (stall !== 1'b1 || we !== 1'b0) begin bad++; $display("FAIL b2b_direct_wait: got %b/%b want 1/0", stall, we); end
    md_result = 32'h22;
    drive_wait(0);
    total++; if (rd !== 5'd8 || data_out !== 32'h22 || we !== 1'b1) begin bad++; $display("FAIL b2b_second: got %0d/%h/%b want 8/22/1", rd, data_out, we); end
    idle_inputs();
    step();
  endtask

  task automatic test_spurious();
    ir_in = mk(5'd5, 5'd10, 5'd0); data_in = 32'h77;
    md_ready = 1'b1; md_result = 32'h99;
    step();
    total++; if (rd !== 5'd10 || data_out !== 32'h77 || stall !== 1'b0) begin bad++; $display("FAIL spurious_write: got %0d/%h/%b want 10/77/0", rd, data_out, stall); end
    ir_in = 32'h0;
    step();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL spurious_stall: got %b want 0", stall); end
    idle_inputs();
  endtask

  task automatic test_clear_mid_wait();
    load_md(mk(5'd0, 5'd13, 5'd6));
    step();
    #2;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL cmw_pre_stall: got %b want 1", stall); end
    clear = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || we !== 1'b0) begin bad++; $display("FAIL cmw_async: got %b/%b want 0/0", stall, we); end
    #1;
    clear = 1'b0;
    md_ready = 1'b1; md_result = 32'hDEAD;
    step();
    total++; if (we !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL cmw_no_write: got %b/%b want 0/0", we, stall); end
    md_ready = 1'b0;
    step();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL cmw_no_write2: got %b want 0", we); end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [4:0]  ops [10] = '{5'd0, 5'd5, 5'd8, 5'd3, 5'd21, 5'd1, 5'd2, 5'd9, 5'd31, 5'd16};
    logic [31:0] i, d, res;
    logic [4:0]  aluop, dst, erd;
    logic        e, ewe, mexc;
    logic [31:0] edata;
    int          lat;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        dst   = 5'($urandom_range(1, 31));
        aluop = $urandom_range(0, 1) ? 5'd7 : 5'd6;
        i     = {5'd0, dst, 15'($urandom), aluop, 2'($urandom)};
        res   = $urandom; mexc = ($urandom_range(0, 3) == 0);
        lat   = $urandom_range(0, 10);
        load_md(i);
        md_result = res; md_exception = mexc;
        for (int w = 0; w <= lat; w++) begin
          total++; if (stall !== 1'b1 || we !== 1'b0) begin bad++; $display("FAIL rnd_wait t=%0d: got %b/%b want 1/0", t, stall, we); end
          ir_in = $urandom; data_in = $urandom; exc_in = $urandom;
          md_ready = (w == lat);
          step();
        end
        md_ready = 1'b0;
        erd   = mexc ? 5'd30 : dst;
        edata = mexc ? (aluop == 5'd7 ? 32'd5 : 32'd4) : res;
        total++; if (we !== 1'b1 || rd !== erd || data_out !== edata || stall !== 1'b0) begin
          bad++; $display("FAIL rnd_md t=%0d: got %b/%0d/%h want 1/%0d/%h", t, we, rd, data_out, erd, edata);
        end
      end else begin
        aluop = 5'($urandom);
        if (aluop == 5'd6 || aluop == 5'd7) aluop = 5'd0;
        i = {ops[$urandom_range(0, 9)], 5'($urandom), 15'($urandom), aluop, 2'($urandom)};
        d = $urandom; e = ($urandom_range(0, 3) == 0);
        ir_in = i; data_in = d; exc_in = e;
        md_ready = $urandom; md_result = $urandom;
        step();
        md_ready = 1'b0;
        ref_single(i, d, e, ewe, erd, edata);
        total++; if (we !== ewe || stall !== 1'b0 || (ewe && (rd !== erd || data_out !== edata))) begin
          bad++; $display("FAIL rnd_single t=%0d ir=%h: got %b/%0d/%h want %b/%0d/%h", t, i, we, rd, data_out, ewe, erd, edata);
        end
      end
    end
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_exc();
    test_mult_wait();
    test_md_exception();
    test_timeout();
    test_back_to_back();
    test_spurious();
    test_clear_mid_wait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
